// File: rtl/fb_write_arbiter.sv
// Two-requester round-robin write arbiter feeding a registered frame-buffer write port.
// Optional full-buffer clear engine, compiled in when FB_ARB_CLEAR_EN is defined.
module fb_write_arbiter #(
  parameter int                ADDR_W      = 15,
  parameter int                DATA_W      = 24,
  parameter int                GRID_SIZE   = 192,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_we,
  output logic              oob
);

  // Handshake: a transfer happens on every rising edge where reqN && gntN.
  // A requester keeps addrN/dataN stable while reqN is high and gntN is low.

  // One extra bit so the bound still compares correctly when GRID_SIZE == 2**ADDR_W.
  localparam logic [ADDR_W:0] GRID_LIM = (ADDR_W+1)'(GRID_SIZE);

  logic              last_win;
  logic              arb_en;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              gnt0_c;
  logic              gnt1_c;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_oob;

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(GRID_SIZE - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;
  logic              clear_done_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      clear_done <= clear_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    clr_cnt_nxt    = clr_cnt;
    clear_done_nxt = 1'b0;
    arb_en         = 1'b0;
    clr_we         = 1'b0;
    case (state)
      ARB: begin
        // A clear request wins over any request in the same cycle.
        if (clear_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end else begin
          arb_en = 1'b1;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt      = ARB;
          clr_cnt_nxt    = '0;
          clear_done_nxt = 1'b1;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
      end
    endcase
  end

  assign clr_addr = clr_cnt;
  // The last clear write shows on fb_* in the clear_done cycle, so busy covers it too.
  assign clear_busy = (state == CLEAR) | clear_done;
`else
  logic clear_start_unused;

  assign clear_start_unused = clear_start;
  assign arb_en             = 1'b1;
  assign clr_we             = 1'b0;
  assign clr_addr           = '0;
  assign clear_busy         = 1'b0;
  assign clear_done         = 1'b0;
`endif

  // Round-robin: on a tie the requester that did not win last time gets the grant.
  assign gnt0_c = arb_en & req0 & (~req1 | last_win);
  assign gnt1_c = arb_en & req1 & ~gnt0_c;
  assign gnt0   = gnt0_c & rst;
  assign gnt1   = gnt1_c & rst;

  assign sel_addr = gnt1_c ? addr1 : addr0;
  assign sel_data = gnt1_c ? data1 : data0;
  assign sel_oob  = ({1'b0, sel_addr} >= GRID_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      oob      <= 1'b0;
      last_win <= 1'b1;
    end else begin
      fb_we <= 1'b0;
      oob   <= 1'b0;
      if (clr_we) begin
        fb_we   <= 1'b1;
        fb_addr <= clr_addr;
        fb_data <= CLEAR_COLOR;
      end else if (gnt0_c | gnt1_c) begin
        last_win <= gnt1_c;
        // Out-of-range transfers are consumed without touching the frame buffer.
        if (sel_oob) begin
          oob <= 1'b1;
        end else begin
          fb_we   <= 1'b1;
          fb_addr <= sel_addr;
          fb_data <= sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter; the clear-engine section follows FB_ARB_CLEAR_EN.
module tb_fb_write_arbiter;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 24;
  localparam int GRID_SIZE = 192;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0, req1, clear_start;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              gnt0, gnt1, clear_busy, clear_done, fb_we, oob;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  int n_checks = 0;
  int n_fail   = 0;

  fb_write_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .GRID_SIZE  (GRID_SIZE),
    .CLEAR_COLOR(24'h000000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .addr0      (addr0),
    .data0      (data0),
    .gnt0       (gnt0),
    .req1       (req1),
    .addr1      (addr1),
    .data1      (data1),
    .gnt1       (gnt1),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .oob        (oob)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0        = 1'b0;
    req1        = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int zero_g, we_cnt, addr_err, data_err, done_cnt, done_at, busy_cnt, gnt1_cnt, exp_a, k;
    idle();
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;

    // Reset state, with a request pending that must not be granted
    rst  = 1'b0;
    req0 = 1'b1;
    #3;
    check_val("rst_gnt0", gnt0, 0);
    check_val("rst_fb_we", fb_we, 0);
    check_val("rst_fb_addr", fb_addr, 0);
    check_val("rst_fb_data", fb_data, 0);
    check_val("rst_oob", oob, 0);
    check_val("rst_busy", clear_busy, 0);
    check_val("rst_done", clear_done, 0);
    do_reset();

    // Lone request: same-cycle grant, write one cycle later, then hold
    req0 = 1'b1; addr0 = 15'd5; data0 = 24'hFF0000;
    #1;
    check_val("lone_gnt0", gnt0, 1);
    check_val("lone_gnt1", gnt1, 0);
    step();
    req0 = 1'b0;
    check_val("lone_we", fb_we, 1);
    check_val("lone_addr", fb_addr, 5);
    check_val("lone_data", fb_data, 24'hFF0000);
    check_val("lone_oob", oob, 0);
    step();
    check_val("idle_we", fb_we, 0);
    check_val("idle_addr_hold", fb_addr, 5);

    // Both requesting from reset: 0,1,0,1 with back-to-back writes
    do_reset();
    req0 = 1'b1; addr0 = 15'd10; data0 = 24'h111111;
    req1 = 1'b1; addr1 = 15'd20; data1 = 24'h222222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      check_val("rr_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
      step();
      check_val("rr_we", fb_we, 1);
      check_val("rr_addr", fb_addr, (i % 2 == 0) ? 10 : 20);
      check_val("rr_data", fb_data, (i % 2 == 0) ? 24'h111111 : 24'h222222);
    end
    idle();
    step();
    check_val("rr_end_we", fb_we, 0);

    // Out-of-range address: granted, no write, oob pulse
    req1 = 1'b1; addr1 = 15'd192; data1 = 24'h333333;
    #1;
    check_val("oob_gnt1", gnt1, 1);
    check_val("oob_gnt0", gnt0, 0);
    step();
    req1 = 1'b0;
    check_val("oob_pulse", oob, 1);
    check_val("oob_we", fb_we, 0);
    check_val("oob_addr_hold", fb_addr, 20);
    step();
    check_val("oob_clear", oob, 0);

    // Highest in-range address
    req0 = 1'b1; addr0 = 15'd191; data0 = 24'h0000FF;
    step();
    req0 = 1'b0;
    check_val("edge_we", fb_we, 1);
    check_val("edge_addr", fb_addr, 191);
    check_val("edge_oob", oob, 0);

    // Tie after requester 0 won goes to requester 1
    req0 = 1'b1; req1 = 1'b1; addr1 = 15'd30; data1 = 24'h444444;
    #1;
    check_val("tie_gnt1", gnt1, 1);
    check_val("tie_gnt0", gnt0, 0);
    step();
    idle();

`ifdef FB_ARB_CLEAR_EN
    // Full clear while requester 0 waits; a second clear_start mid-way is ignored
    req0 = 1'b1; addr0 = 15'd7; data0 = 24'h123456; clear_start = 1'b1;
    #1;
    check_val("clr_prio_gnt0", gnt0, 0);
    step();
    clear_start = 1'b0;
    zero_g = 1; we_cnt = 0; addr_err = 0; data_err = 0;
    done_cnt = 0; done_at = 0; busy_cnt = 0; gnt1_cnt = 0; exp_a = 0;
    for (int c = 1; c <= 193; c++) begin
      clear_start = (c == 50);
      if (c == 192) req1 = 1'b1;
      #1;
      if (!gnt0) zero_g++;
      if (gnt1) gnt1_cnt++;
      if (fb_we) begin
        if (fb_addr != ADDR_W'(exp_a)) addr_err++;
        if (fb_data != 24'h000000) data_err++;
        exp_a++;
        we_cnt++;
      end
      if (clear_done) begin
        done_cnt++;
        done_at = c;
      end
      if (clear_busy) busy_cnt++;
      if (c == 193) check_val("clr_gnt0_after", gnt0, 1);
      step();
    end
    clear_start = 1'b0;
    idle();
    check_val("clr_gnt0_zero_cycles", zero_g, 193);
    check_val("clr_gnt1_cycles", gnt1_cnt, 0);
    check_val("clr_we_cycles", we_cnt, 192);
    check_val("clr_addr_errors", addr_err, 0);
    check_val("clr_data_errors", data_err, 0);
    check_val("clr_done_count", done_cnt, 1);
    check_val("clr_done_cycle", done_at, 193);
    check_val("clr_busy_cycles", busy_cnt, 193);
    check_val("post_clr_we", fb_we, 1);
    check_val("post_clr_addr", fb_addr, 7);
    check_val("post_clr_data", fb_data, 24'h123456);
    check_val("post_clr_done", clear_done, 0);
    check_val("post_clr_busy", clear_busy, 0);

    // Reset in the middle of a clear
    req0 = 1'b1; addr0 = 15'd9; data0 = 24'hABCDEF; clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    k = 0;
    while (!(fb_we && fb_addr == 15'd50) && k < 300) begin
      step();
      k++;
    end
    check_val("abort_reach50", (k < 300) ? 1 : 0, 1);
    rst = 1'b0;
    #1;
    check_val("abort_we", fb_we, 0);
    check_val("abort_addr", fb_addr, 0);
    check_val("abort_busy", clear_busy, 0);
    check_val("abort_gnt0", gnt0, 0);
    step();
    rst = 1'b1;
    #1;
    check_val("abort_first_gnt0", gnt0, 1);
    done_cnt = 0;
    step();
    if (clear_done) done_cnt++;
    check_val("abort_first_we", fb_we, 1);
    check_val("abort_first_addr", fb_addr, 9);
    idle();
    for (int c = 0; c < 4; c++) begin
      step();
      if (clear_done) done_cnt++;
    end
    check_val("abort_no_done", done_cnt, 0);
`else
    // Clear engine absent: clear_start changes nothing
    req0 = 1'b1; addr0 = 15'd3; data0 = 24'h0A0B0C; clear_start = 1'b1;
    #1;
    check_val("noclr_gnt0", gnt0, 1);
    check_val("noclr_busy", clear_busy, 0);
    step();
    idle();
    check_val("noclr_we", fb_we, 1);
    check_val("noclr_addr", fb_addr, 3);
    check_val("noclr_data", fb_data, 24'h0A0B0C);
    we_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (fb_we) we_cnt++;
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
    end
    check_val("noclr_idle_we", we_cnt, 0);
    check_val("noclr_idle_busy", busy_cnt, 0);
    check_val("noclr_idle_done", done_cnt, 0);
`endif

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 15, frame-buffer address width.
REQ-002 The block SHALL take parameter DATA_W, default 24, pixel data width (RGB888).
REQ-003 The block SHALL take parameter GRID_SIZE, default 192, number of valid frame-buffer locations (16x12 virtual grid).
REQ-004 The block SHALL take parameter CLEAR_COLOR, default 24'h000000, value written by the clear engine.
REQ-005 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req0  in  1  requester 0 write request.
- addr0  in  ADDR_W  requester 0 address.
- data0  in  DATA_W  requester 0 data.
- gnt0  out  1  requester 0 grant (combinational).
- req1, addr1, data1, gnt1  as above  requester 1.
- clear_start  in  1  single-cycle pulse that starts a full-buffer clear.
- clear_busy  out  1  high while a clear is in progress.
- clear_done  out  1  single-cycle pulse when a clear completes.
- fb_addr  out  ADDR_W  frame-buffer write address (registered).
- fb_data  out  DATA_W  frame-buffer write data (registered).
- fb_we  out  1  frame-buffer write strobe (registered).
- oob  out  1  single-cycle pulse when a granted address is >= GRID_SIZE.

Function
REQ-006 A transfer SHALL occur on any clock edge where reqN and gntN are both high; the requester holds addrN and dataN stable while reqN is high and gntN is low.
REQ-007 At most one gnt SHALL be high in any cycle; gntN SHALL never be high while reqN is low.
REQ-008 In state ARB, a lone request SHALL be granted in the same cycle.
REQ-009 In state ARB, when both requests are high, the grant SHALL go to the requester other than the last winner (round-robin). Last winner resets to 1, so requester 0 wins the first tie.
REQ-010 A transfer with an in-range address SHALL drive fb_we=1, fb_addr=addrN and fb_data=dataN on the following cycle (latency 1). Back-to-back transfers SHALL sustain one write per cycle.
REQ-011 A transfer with addrN >= GRID_SIZE SHALL be consumed: it is granted, fb_we stays 0, and oob pulses high for one cycle on the following cycle.
REQ-012 With no transfer, fb_we SHALL be 0 on the following cycle; fb_addr and fb_data hold their previous values.
REQ-013 The state machine SHALL have two states, ARB and CLEAR. clear_start in ARB moves the machine to CLEAR on the next edge, and clear_start has priority over any same-cycle request, which is not granted.
REQ-014 In CLEAR, gnt0 and gnt1 SHALL be 0. The block SHALL write CLEAR_COLOR to addresses 0 through GRID_SIZE-1 in ascending order, one write per cycle, so fb_we is high for exactly GRID_SIZE consecutive cycles.
REQ-015 clear_busy SHALL be high from the cycle after clear_start through the cycle of the last clear write on fb_*.
REQ-016 clear_done SHALL pulse high for one cycle on the cycle immediately after the last clear write, and the machine returns to ARB in that same cycle.
REQ-017 clear_start asserted while in CLEAR SHALL be ignored and SHALL not restart the address counter.
REQ-018 The round-robin last-winner state SHALL be preserved across a clear.

Reset
REQ-019 While rst=0, all of the following SHALL hold asynchronously:
- state = ARB;
- fb_we, oob, clear_busy, clear_done, gnt0 and gnt1 = 0;
- fb_addr and fb_data = 0;
- clear counter = 0;
- last winner = 1.
REQ-020 Reset asserted during a clear SHALL abort the clear with no clear_done pulse. The first edge after rst deasserts SHALL start in ARB.

Configuration
REQ-021 Macro FB_ARB_CLEAR_EN SHALL control the clear engine.
- Defined: the clear engine and the CLEAR state are compiled in, as described above.
- Undefined: clear_start is ignored, clear_busy and clear_done are tied to 0, and the block is a pure two-way round-robin arbiter.

Verification
REQ-022 req0=1 with addr0=5 and data0=24'hFF0000 alone -> gnt0=1 the same cycle; next cycle fb_we=1, fb_addr=5, fb_data=FF0000.
REQ-023 req0 and req1 both held high for 4 cycles after reset -> grants alternate 0,1,0,1; fb_we high for 4 consecutive cycles.
REQ-024 req1=1 with addr1=192 -> gnt1=1; next cycle oob=1 and fb_we=0.
REQ-025 clear_start pulse with req0 held high -> gnt0=0 for 193 cycles; fb_we high for 192 cycles with fb_addr 0..191 and fb_data=0; clear_done pulses once; gnt0=1 in that same cycle.
REQ-026 rst=0 at clear address 50 -> all outputs 0 immediately; after release no clear_done pulse, and the first request is granted.
REQ-027 With FB_ARB_CLEAR_EN undefined, a clear_start pulse -> no fb_we, clear_busy=0, and requests are still granted normally.
